// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, frame width, baud divisor.
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_states;

  // Bit period in clk cycles; truncating division matches the transmitter's divisor.
  function automatic int unsigned baud_scale(input int unsigned clk_mhz,
                                             input int unsigned boadrate);
    return (clk_mhz * 32'd1000 * 32'd1000) / boadrate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an idle-high asynchronous input; latency N cycles.
// Flops reset to 1 so a held reset looks like an idle line, never a start bit.
module uart_rx_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output; UART_RX_MAJORITY_EN selects 2-of-3 data/stop sampling.
// Byte appears 2 cycles after the stop-bit sample; a byte arriving while one is still held is dropped with an overrun pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int boadrate = 9600
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       rx,
  output logic       down_valid,
  input  logic       down_ready,
  output logic [7:0] down_data,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned SCALE   = baud_scale(clk_mhz, boadrate);
  localparam int unsigned HALF    = SCALE / 2;
  localparam logic [31:0] SCALE_M1 = 32'(SCALE - 1);
  localparam logic [31:0] HALF_M1  = 32'(HALF - 1);
  localparam logic [2:0]  LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync #(.N(2)) u_sync (
    .clk   (clk),
    .arstn (arstn),
    .d     (rx),
    .q     (rx_s)
  );

  rx_states    state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        deliver_q, deliver_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        down_valid_q, down_valid_d;
  logic [7:0]  down_data_q, down_data_d;

  logic tick;
  logic samp_evt;
  logic samp_bit;

  assign tick = (cnt_q == 32'd0);

`ifdef UART_RX_MAJORITY_EN
  // Samples at cnt==1 and at the tick are held; the third is the live rx_s one cycle later.
  logic s1_q, s1_d;
  logic s0_q, s0_d;
  logic evt_q, evt_d;

  always_comb begin
    s1_d  = (cnt_q == 32'd1) ? rx_s : s1_q;
    s0_d  = tick ? rx_s : s0_q;
    evt_d = tick && ((state_q == DATA) || (state_q == STOP));
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_q  <= 1'b1;
      s0_q  <= 1'b1;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s0_q  <= s0_d;
      evt_q <= evt_d;
    end
  end

  assign samp_evt = evt_q;
  assign samp_bit = (s1_q & s0_q) | (s1_q & rx_s) | (s0_q & rx_s);
`else
  assign samp_evt = tick && ((state_q == DATA) || (state_q == STOP));
  assign samp_bit = rx_s;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? SCALE_M1 : cnt_q - 32'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        // A start bit that is high again at mid-period was a glitch: drop silently.
        if (tick) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (samp_evt) begin
          shift_d   = {samp_bit, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (samp_evt) begin
          if (samp_bit) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    down_valid_d = down_valid_q & ~down_ready;
    down_data_d  = down_data_q;
    overrun_d    = 1'b0;
    if (deliver_q) begin
      if (!down_valid_q || down_ready) begin
        down_valid_d = 1'b1;
        down_data_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= IDLE;
      cnt_q        <= 32'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      deliver_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      down_valid_q <= 1'b0;
      down_data_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      deliver_q    <= deliver_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
